// File: rtl/home_cell_pos_reader.sv
// Sweeps the home-cell position memory twice (phase 0, then phase 1), stalling on any
// filter back-pressure, and emits per-beat sideband flags aligned with the memory data.
module home_cell_pos_reader #(
    parameter int NUM_FILTER = 7,
    parameter int ADDR_W     = 7
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [ADDR_W-1:0]         home_particle_num,
    input  logic [ADDR_W-1:0]         ref_particle_id,
    input  logic [NUM_FILTER-1:0]     back_pressure,
    output logic [ADDR_W-1:0]         rd_addr,
    output logic                      rd_en,
    output logic                      phase,
    output logic                      pause_reading,
    output logic                      ref_particle_read,
    output logic [2*NUM_FILTER-1:0]   broadcast_done,
    output logic                      busy,
    output logic                      done
);

    localparam int NB = 2 * NUM_FILTER;

    typedef enum logic [1:0] {IDLE, PH0, PH1, DRAIN} state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] n_q, r_q, addr_next;
    logic              last_addr, busy_next, done_next;
    logic [NB-1:0]     bd_next;

    always_comb begin
        state_next = state;
        addr_next  = rd_addr;
        rd_en      = 1'b0;
        busy_next  = 1'b0;
        done_next  = 1'b0;
        last_addr  = (rd_addr == n_q - ADDR_W'(1));
        case (state)
            IDLE: begin
                if (start) begin
                    busy_next = 1'b1;
                    if (home_particle_num != '0) state_next = PH0;
                    else                         done_next  = 1'b1;
                end
            end
            PH0, PH1: begin
                busy_next = 1'b1;
                rd_en     = ~|back_pressure;
                if (rd_en) begin
                    if (last_addr) begin
                        addr_next  = '0;
                        state_next = (state == PH0) ? PH1 : DRAIN;
                    end else begin
                        addr_next = rd_addr + ADDR_W'(1);
                    end
                end
            end
            DRAIN: begin
                done_next  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        // Each phase clears the done flags of its own seven neighbour cells.
        if (!rd_en)            bd_next = '1;
        else if (state == PH1) bd_next = {{NUM_FILTER{1'b0}}, {NUM_FILTER{1'b1}}};
        else                   bd_next = {{NUM_FILTER{1'b1}}, {NUM_FILTER{1'b0}}};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            rd_addr           <= '0;
            n_q               <= '0;
            r_q               <= '0;
            phase             <= 1'b0;
            pause_reading     <= 1'b1;
            ref_particle_read <= 1'b0;
            broadcast_done    <= '1;
            busy              <= 1'b0;
            done              <= 1'b0;
        end else begin
            state   <= state_next;
            rd_addr <= addr_next;
            if (state == IDLE && start) begin
                n_q <= home_particle_num;
                r_q <= ref_particle_id;
            end
            phase             <= (state == PH1);
            pause_reading     <= ~rd_en;
            ref_particle_read <= rd_en && (rd_addr > r_q);
            broadcast_done    <= bd_next;
            busy              <= busy_next;
            done              <= done_next;
        end
    end

endmodule

// File: tb/tb_home_cell_pos_reader.sv
// Scoreboard bench for home_cell_pos_reader: directed sweeps plus randomized sizes,
// reference ids and back-pressure, checked against a read-count model of the sweep.
module tb_home_cell_pos_reader;

    localparam int NF = 7;
    localparam int AW = 7;
    localparam int NB = 2 * NF;

    logic          clk = 1'b0;
    logic          rst, start;
    logic [AW-1:0] hnum, rid;
    logic [NF-1:0] bp;
    logic [AW-1:0] rd_addr;
    logic          rd_en, phase, pause_reading, ref_particle_read, busy, done;
    logic [NB-1:0] broadcast_done;

    always #5 clk = ~clk;

    home_cell_pos_reader #(.NUM_FILTER(NF), .ADDR_W(AW)) dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .home_particle_num (hnum),
        .ref_particle_id   (rid),
        .back_pressure     (bp),
        .rd_addr           (rd_addr),
        .rd_en             (rd_en),
        .phase             (phase),
        .pause_reading     (pause_reading),
        .ref_particle_read (ref_particle_read),
        .broadcast_done    (broadcast_done),
        .busy              (busy),
        .done              (done)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: returns the index that was read, one cycle later.
    logic [AW-1:0] mem_idx;
    always @(posedge clk) if (rd_en) mem_idx <= rd_addr;

    typedef struct {
        int            idx;
        bit            ph;
        bit            rpr;
        logic [NB-1:0] bd;
    } beat_t;

    beat_t q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic push_beats(input int n, input int r);
        beat_t b;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < n; i++) begin
                b.idx = i;
                b.ph  = (p == 1);
                b.rpr = (i > r);
                b.bd  = (p == 1) ? 14'h007F : 14'h3F80;
                q.push_back(b);
            end
        end
    endtask

    // Reference model: a sweep of N issues 2N reads on back-pressure-free cycles,
    // then one idle drain cycle, then done.
    bit m_active = 0, m_busy = 0, m_prev_rd = 0;
    int m_left = 0, m_done_at = -1;

    always @(negedge clk) begin
        beat_t b;
        bit    exp_rd;
        if (rst) begin
            m_active  = 0;
            m_busy    = 0;
            m_prev_rd = 0;
            m_left    = 0;
            m_done_at = -1;
            q.delete();
        end else begin
            exp_rd = m_active && (m_left > 0) && (bp == '0);
            check("rd_en", rd_en, exp_rd);
            check("busy", busy, m_busy);
            check("done", done, cyc == m_done_at);
            check("pause_reading", pause_reading, !m_prev_rd);
            if (!m_active) check("rd_addr_idle", rd_addr, 0);
            if (m_prev_rd) begin
                if (q.size() == 0) begin
                    check("beat_unexpected", 1, 0);
                end else begin
                    b = q.pop_front();
                    check("beat_index", mem_idx, b.idx);
                    check("phase", phase, b.ph);
                    check("ref_particle_read", ref_particle_read, b.rpr);
                    check("broadcast_done", broadcast_done, b.bd);
                end
            end else begin
                check("broadcast_done_idle", broadcast_done, 14'h3FFF);
            end
            if (cyc == m_done_at) check("beats_left_at_done", q.size(), 0);

            m_prev_rd = exp_rd;
            if (m_active) begin
                if (m_left == 0) begin
                    m_active  = 0;
                    m_busy    = 0;
                    m_done_at = cyc + 1;
                end else if (exp_rd) begin
                    m_left--;
                end
            end else if (start) begin
                m_busy = 1;
                if (hnum == 0) m_done_at = cyc + 1;
                else begin
                    m_active = 1;
                    m_left   = 2 * int'(hnum);
                end
            end else begin
                m_busy = 0;
            end
        end
    end

    // mode 0: no stall, 1: bp=0000100 on cycles 3-4, 2: random stalls.
    task automatic run_sweep(input int n, input int r, input int mode, input int exp_lat,
                             input int extra_k);
        int s;
        bit seen;
        seen = 0;
        @(posedge clk); #1;
        start = 1'b1;
        hnum  = AW'(n);
        rid   = AW'(r);
        bp    = '0;
        s     = cyc;
        if (n > 0) push_beats(n, r);
        for (int k = 1; k < 3000 && !seen; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            hnum  = AW'($urandom);
            rid   = AW'($urandom);
            case (mode)
                1:       bp = (k == 3 || k == 4) ? 7'b0000100 : '0;
                2:       bp = ($urandom_range(0, 3) == 0) ? NF'($urandom_range(1, 127)) : '0;
                default: bp = '0;
            endcase
            if (k == extra_k) begin
                start = 1'b1;
                hnum  = AW'($urandom_range(1, 127));
                rid   = AW'($urandom);
            end
            @(negedge clk);
            if (done) seen = 1;
        end
        if (!seen)            check("done_timeout", 0, 1);
        else if (exp_lat > 0) check("done_latency", cyc - s, exp_lat);
    endtask

    task automatic reset_mid_sweep();
        @(posedge clk); #1;
        start = 1'b1;
        hnum  = 7'd4;
        rid   = 7'd1;
        bp    = '0;
        push_beats(4, 1);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (k == 4) rst = 1'b1;
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_rd_en", rd_en, 0);
        check("rst_phase", phase, 0);
        check("rst_pause", pause_reading, 1);
        check("rst_ref_read", ref_particle_read, 0);
        check("rst_bdone", broadcast_done, 14'h3FFF);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        repeat (15) @(negedge clk);
        run_sweep(4, 1, 0, 10, 0);
    endtask

    initial begin
        int n, r;
        rst   = 1'b1;
        start = 1'b0;
        hnum  = '0;
        rid   = '0;
        bp    = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        run_sweep(4, 1, 0, 10, 0);
        run_sweep(4, 1, 1, 12, 0);
        run_sweep(0, 0, 0, 1, 0);
        run_sweep(4, 1, 0, 10, 6);
        reset_mid_sweep();
        run_sweep(1, 0, 0, 4, 0);
        run_sweep(5, 4, 2, 0, 0);
        run_sweep(3, 100, 2, 0, 0);
        run_sweep(127, 0, 0, 256, 0);
        run_sweep(127, 126, 2, 0, 0);
        repeat (25) begin
            n = $urandom_range(0, 30);
            r = $urandom_range(0, 40);
            run_sweep(n, r, 2, 0, 0);
        end

        repeat (3) @(negedge clk);
        check("queue_final", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
